// File: rtl/nco_sweep_pkg.sv
// Shared widths, reset increment, sweep state encoding and the
// down-to-up phase mapping used by the NCO sweep controller.
package nco_sweep_pkg;

   localparam int SWEEP_PW          = 19;
   localparam int SWEEP_UPW         = 23;
   localparam int SWEEP_DWELL_W     = 16;
   localparam int SWEEP_DEFAULT_INC = 80652;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARM   = 3'd1,
      DWELL = 3'd2,
      STEP  = 3'd3,
      DONE  = 3'd4
   } sweep_state_e;

   // Up-converter runs the inverted LO at 16x phase resolution.
   function automatic logic [SWEEP_UPW-1:0] phase_to_up(input logic [SWEEP_PW-1:0] phase);
      return SWEEP_UPW'(0) - {phase, 4'b0000};
   endfunction

endpackage

// File: rtl/nco_phase_acc.sv
// Free-running LO phase accumulator with the matching up-converter phase.
module nco_phase_acc
   import nco_sweep_pkg::*;
#(
   parameter int PW  = SWEEP_PW,
   parameter int UPW = SWEEP_UPW
) (
   input  logic           sys_clk,
   input  logic           rst_n,
   input  logic [PW-1:0]  inc_i,
   output logic [PW-1:0]  phase_o,
   output logic [UPW-1:0] phase_up_o
);

   logic [PW-1:0] phase_q;
   logic [PW-1:0] phase_d;

   assign phase_d = phase_q + inc_i;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

   assign phase_o    = phase_q;
   assign phase_up_o = phase_to_up(phase_q);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// LO sweep sequencer: linear increment sweep aligned to sample_ce, driving the
// shared phase accumulator. Optional DAC muting around LO jumps: SWEEP_DAC_MUTE_EN.
module nco_sweep_ctrl
   import nco_sweep_pkg::*;
#(
   parameter int             PW          = SWEEP_PW,
   parameter int             UPW         = SWEEP_UPW,
   parameter int             DWELL_W     = SWEEP_DWELL_W,
   parameter logic [PW-1:0]  DEFAULT_INC = PW'(SWEEP_DEFAULT_INC)
) (
   input  logic               sys_clk,
   input  logic               rst_n,
   input  logic [PW-1:0]      cfg_start_inc,
   input  logic [PW-1:0]      cfg_stop_inc,
   input  logic [PW-1:0]      cfg_step,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic               cfg_loop,
   input  logic               cmd_start,
   input  logic               cmd_abort,
   input  logic               sample_ce,
   output logic [PW-1:0]      phase_out,
   output logic [UPW-1:0]     phase_up_out,
   output logic [PW-1:0]      phase_inc,
   output logic               busy,
   output logic               done,
   output logic               dac_mute
);

   sweep_state_e       state_q, state_d;
   logic [PW-1:0]      inc_q, inc_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;

   logic [PW-1:0]      start_q, stop_q, step_q;
   logic [DWELL_W-1:0] reload_q;
   logic               loop_q, down_q;
   logic               accept;

   logic [PW:0]        up_next, dn_next, next_inc;
   logic               passes_stop;

   // One extra bit so a step past either rail shows up as a carry/borrow.
   assign up_next = {1'b0, inc_q} + {1'b0, step_q};
   assign dn_next = {1'b0, inc_q} - {1'b0, step_q};

   always_comb begin
      next_inc    = up_next;
      passes_stop = up_next[PW] | (up_next[PW-1:0] > stop_q);
      if (down_q) begin
         next_inc    = dn_next;
         passes_stop = dn_next[PW] | (dn_next[PW-1:0] < stop_q);
      end
   end

   always_comb begin
      state_d = state_q;
      inc_d   = inc_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_start && !cmd_abort) begin
               accept  = 1'b1;
               state_d = ARM;
            end
         end
         ARM: begin
            if (sample_ce) begin
               inc_d   = start_q;
               cnt_d   = reload_q;
               state_d = DWELL;
            end
         end
         DWELL: begin
            if (sample_ce) begin
               if (cnt_q == '0) begin
                  state_d = STEP;
               end else begin
                  cnt_d = cnt_q - DWELL_W'(1);
               end
            end
         end
         STEP: begin
            if (inc_q == stop_q) begin
               state_d = loop_q ? ARM : DONE;
            end else if (step_q == '0) begin
               inc_d   = stop_q;
               state_d = DONE;
            end else if (passes_stop) begin
               // Clamped stop value still gets its own full dwell.
               inc_d   = stop_q;
               cnt_d   = reload_q;
               state_d = DWELL;
            end else begin
               inc_d   = next_inc[PW-1:0];
               cnt_d   = reload_q;
               state_d = DWELL;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (state_q != IDLE && cmd_abort) begin
         state_d = IDLE;
         inc_d   = inc_q;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         inc_q   <= DEFAULT_INC;
      end else begin
         state_q <= state_d;
         inc_q   <= inc_d;
      end
   end

   always_ff @(posedge sys_clk) begin
      cnt_q <= cnt_d;
      if (accept) begin
         start_q  <= cfg_start_inc;
         stop_q   <= cfg_stop_inc;
         step_q   <= cfg_step;
         reload_q <= (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);
         loop_q   <= cfg_loop;
         down_q   <= (cfg_start_inc > cfg_stop_inc);
      end
   end

   nco_phase_acc #(
      .PW  (PW),
      .UPW (UPW)
   ) u_acc (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .inc_i      (inc_q),
      .phase_o    (phase_out),
      .phase_up_o (phase_up_out)
   );

   assign phase_inc = inc_q;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);

`ifdef SWEEP_DAC_MUTE_EN
   logic mute_pend_q;

   // Pending flag covers the first sample period after every entry into DWELL.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         mute_pend_q <= 1'b0;
      end else begin
         mute_pend_q <= (state_d == DWELL) &&
                        ((state_q != DWELL) || (mute_pend_q && !sample_ce));
      end
   end

   assign dac_mute = (state_q == ARM) || (state_q == STEP) ||
                     ((state_q == DWELL) && mute_pend_q);
`else
   assign dac_mute = 1'b0;
`endif

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl: accumulator, up/down/zero-step sweeps,
// abort, loop mode, DAC mute and asynchronous reset.
module tb_nco_sweep_ctrl;

   localparam int PW  = 19;
   localparam int UPW = 23;
   localparam int DW  = 16;
`ifdef SWEEP_DAC_MUTE_EN
   localparam int MUTE_EN = 1;
`else
   localparam int MUTE_EN = 0;
`endif

   logic           sys_clk = 1'b0;
   logic           rst_n   = 1'b0;
   logic [PW-1:0]  cfg_start_inc = '0;
   logic [PW-1:0]  cfg_stop_inc  = '0;
   logic [PW-1:0]  cfg_step      = '0;
   logic [DW-1:0]  cfg_dwell     = '0;
   logic           cfg_loop      = 1'b0;
   logic           cmd_start     = 1'b0;
   logic           cmd_abort     = 1'b0;
   logic           sample_ce     = 1'b0;
   logic [PW-1:0]  phase_out;
   logic [UPW-1:0] phase_up_out;
   logic [PW-1:0]  phase_inc;
   logic           busy;
   logic           done;
   logic           dac_mute;

   int tests     = 0;
   int failed    = 0;
   int done_seen = 0;
   int done_ref  = 0;
   longint exp_phase;

   nco_sweep_ctrl dut (
      .sys_clk       (sys_clk),
      .rst_n         (rst_n),
      .cfg_start_inc (cfg_start_inc),
      .cfg_stop_inc  (cfg_stop_inc),
      .cfg_step      (cfg_step),
      .cfg_dwell     (cfg_dwell),
      .cfg_loop      (cfg_loop),
      .cmd_start     (cmd_start),
      .cmd_abort     (cmd_abort),
      .sample_ce     (sample_ce),
      .phase_out     (phase_out),
      .phase_up_out  (phase_up_out),
      .phase_inc     (phase_inc),
      .busy          (busy),
      .done          (done),
      .dac_mute      (dac_mute)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) begin
      if (done === 1'b1) done_seen <= done_seen + 1;
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clk1();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic ce_tick();
      sample_ce = 1'b1;
      clk1();
      sample_ce = 1'b0;
      clk1();
      clk1();
      clk1();
   endtask

   task automatic set_cfg(input int s, input int p, input int st, input int d, input bit l);
      cfg_start_inc = PW'(s);
      cfg_stop_inc  = PW'(p);
      cfg_step      = PW'(st);
      cfg_dwell     = DW'(d);
      cfg_loop      = l;
   endtask

   task automatic start_pulse();
      cmd_start = 1'b1;
      clk1();
      cmd_start = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (3) clk1();
      chk("rst_phase", phase_out, 0);
      chk("rst_phase_up", phase_up_out, 0);
      chk("rst_inc", phase_inc, 80652);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mute", dac_mute, 0);

      // Free-running accumulator at the default increment
      rst_n = 1'b1;
      clk1();
      chk("acc_1", phase_out, 80652);
      chk("acc_up_1", phase_up_out, 7098176);
      exp_phase = 80652;
      for (int i = 2; i <= 7; i++) begin
         clk1();
         exp_phase = (exp_phase + 80652) % 524288;
         chk("acc_n", phase_out, exp_phase);
         chk("acc_up_n", phase_up_out, (8388608 - exp_phase * 16) % 8388608);
      end
      chk("acc_wrap", phase_out, 40276);

      // Up sweep 1000..1300 step 100, dwell 2
      set_cfg(1000, 1300, 100, 2, 1'b0);
      start_pulse();
      set_cfg(5555, 9999, 7, 9, 1'b1);
      chk("up_busy_arm", busy, 1);
      chk("up_inc_hold", phase_inc, 80652);
      chk("up_mute_arm", dac_mute, MUTE_EN);
      sample_ce = 1'b1;
      clk1();
      sample_ce = 1'b0;
      chk("up_inc_latency", phase_inc, 1000);
      chk("up_mute_dwell1", dac_mute, MUTE_EN);
      clk1(); clk1(); clk1();
      ce_tick();
      chk("up_1000_b", phase_inc, 1000);
      chk("up_mute_clear", dac_mute, 0);
      ce_tick();
      chk("up_1100_a", phase_inc, 1100);
      chk("up_mute_step", dac_mute, MUTE_EN);
      ce_tick();
      chk("up_1100_b", phase_inc, 1100);
      ce_tick();
      chk("up_1200_a", phase_inc, 1200);
      ce_tick();
      chk("up_1200_b", phase_inc, 1200);
      ce_tick();
      chk("up_1300_a", phase_inc, 1300);
      ce_tick();
      chk("up_1300_b", phase_inc, 1300);
      chk("up_busy_mid", busy, 1);
      chk("up_no_done_yet", done_seen, done_ref);
      ce_tick();
      done_ref++;
      chk("up_done_pulse", done_seen, done_ref);
      chk("up_busy_end", busy, 0);
      chk("up_inc_end", phase_inc, 1300);
      chk("up_mute_idle", dac_mute, 0);

      // Down sweep with overshoot clamp, dwell 1
      set_cfg(500, 260, 100, 1, 1'b0);
      start_pulse();
      ce_tick();
      chk("dn_500", phase_inc, 500);
      ce_tick();
      chk("dn_400", phase_inc, 400);
      ce_tick();
      chk("dn_300", phase_inc, 300);
      ce_tick();
      chk("dn_260", phase_inc, 260);
      chk("dn_busy", busy, 1);
      ce_tick();
      done_ref++;
      chk("dn_done", done_seen, done_ref);
      chk("dn_busy_end", busy, 0);
      chk("dn_inc_end", phase_inc, 260);

      // Zero step with zero dwell: one dwell at start, then stop value and done
      set_cfg(700, 900, 0, 0, 1'b0);
      start_pulse();
      ce_tick();
      chk("z_700", phase_inc, 700);
      chk("z_busy", busy, 1);
      ce_tick();
      done_ref++;
      chk("z_done", done_seen, done_ref);
      chk("z_inc_end", phase_inc, 900);
      chk("z_busy_end", busy, 0);

      // Abort in the third dwell, with a simultaneous start
      set_cfg(1000, 1300, 100, 2, 1'b0);
      start_pulse();
      repeat (5) ce_tick();
      chk("ab_pre", phase_inc, 1200);
      cmd_abort = 1'b1;
      cmd_start = 1'b1;
      clk1();
      cmd_abort = 1'b0;
      cmd_start = 1'b0;
      chk("ab_busy", busy, 0);
      chk("ab_inc", phase_inc, 1200);
      chk("ab_mute", dac_mute, 0);
      cmd_abort = 1'b1;
      cmd_start = 1'b1;
      clk1();
      cmd_abort = 1'b0;
      cmd_start = 1'b0;
      chk("ab_start_drop", busy, 0);
      ce_tick();
      ce_tick();
      chk("ab_inc_frozen", phase_inc, 1200);
      chk("ab_no_done", done_seen, done_ref);

      // Loop mode 10..30 step 10, dwell 1; start while busy is ignored
      set_cfg(10, 30, 10, 1, 1'b1);
      start_pulse();
      ce_tick();
      chk("lp_10", phase_inc, 10);
      ce_tick();
      chk("lp_20", phase_inc, 20);
      ce_tick();
      chk("lp_30", phase_inc, 30);
      ce_tick();
      chk("lp_30_arm", phase_inc, 30);
      chk("lp_busy_arm", busy, 1);
      chk("lp_mute_arm", dac_mute, MUTE_EN);
      set_cfg(400, 100, 50, 3, 1'b0);
      start_pulse();
      ce_tick();
      chk("lp_restart_10", phase_inc, 10);
      ce_tick();
      chk("lp_20_again", phase_inc, 20);
      chk("lp_busy", busy, 1);
      chk("lp_no_done", done_seen, done_ref);

      // Asynchronous reset mid-dwell
      rst_n = 1'b0;
      #1;
      chk("ar_phase", phase_out, 0);
      chk("ar_phase_up", phase_up_out, 0);
      chk("ar_inc", phase_inc, 80652);
      chk("ar_busy", busy, 0);
      chk("ar_done", done, 0);
      chk("ar_mute", dac_mute, 0);
      clk1();
      rst_n = 1'b1;
      clk1();
      chk("ar_acc_restart", phase_out, 80652);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
